// File: rtl/mul_sched_pkg.sv
// Shared types and defaults for the multiply writeback scheduler.
// State encoding plus datapath and counter width constants.
package mul_sched_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 4;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB_LO,
    WB_HI
  } state_e;

endpackage

// File: rtl/mul_wb_scheduler_wb_arbiter.sv
// Two-way fixed-priority register write-port mux, ALU first.
// mul_gnt tells the sequencer its writeback went through this cycle.
module wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              en,
  input  logic              alu_req,
  input  logic [REG_AW-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mul_req,
  input  logic [REG_AW-1:0] mul_addr,
  input  logic [DATA_W-1:0] mul_data,
  output logic              we,
  output logic [REG_AW-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              mul_gnt
);

  always_comb begin
    we      = 1'b0;
    waddr   = '0;
    wdata   = '0;
    mul_gnt = 1'b0;
    if (en) begin
      priority case (1'b1)
        alu_req: begin
          we    = 1'b1;
          waddr = alu_addr;
          wdata = alu_data;
        end
        mul_req: begin
          we      = 1'b1;
          waddr   = mul_addr;
          wdata   = mul_data;
          mul_gnt = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mul_wb_scheduler.sv
// Multiply sequencer and register write-port scheduler.
// MUL_WB_HI_EN builds the high-half writeback; otherwise only lo is written.
module mul_wb_scheduler
  import mul_sched_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int MUL_LAT = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              mul_req,
  input  logic [REG_AW-1:0] mul_rd_lo,
  input  logic [REG_AW-1:0] mul_rd_hi,
  output logic              mul_ack,
  output logic              mul_en,
  input  logic [DATA_W-1:0] mul_lo,
  input  logic [DATA_W-1:0] mul_hi,
  input  logic              alu_wr_req,
  input  logic [REG_AW-1:0] alu_wr_reg,
  input  logic [DATA_W-1:0] alu_wr_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] rd_lo_q, rd_lo_d;
  logic [DATA_W-1:0] prod_lo_q, prod_lo_d;
  logic              ack_q, ack_d;
  logic              take;
  logic              wb_req;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              mul_gnt;

`ifdef MUL_WB_HI_EN
  logic [REG_AW-1:0] rd_hi_q, rd_hi_d;
  logic [DATA_W-1:0] prod_hi_q, prod_hi_d;
`else
  logic unused_hi;
  assign unused_hi = ^{mul_rd_hi, mul_hi};
`endif

  wb_arbiter #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_arb (
    .en      (reset),
    .alu_req (alu_wr_req),
    .alu_addr(alu_wr_reg),
    .alu_data(alu_wr_data),
    .mul_req (wb_req),
    .mul_addr(wb_addr),
    .mul_data(wb_data),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .mul_gnt (mul_gnt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_lo_d   = rd_lo_q;
    prod_lo_d = prod_lo_q;
`ifdef MUL_WB_HI_EN
    rd_hi_d   = rd_hi_q;
    prod_hi_d = prod_hi_q;
`endif
    ack_d   = 1'b0;
    take    = 1'b0;
    wb_req  = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    unique case (state_q)
      IDLE: take = mul_req;
      EXEC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          prod_lo_d = mul_lo;
`ifdef MUL_WB_HI_EN
          prod_hi_d = mul_hi;
`endif
          state_d = WB_LO;
        end
      end
      WB_LO: begin
        wb_req  = 1'b1;
        wb_addr = rd_lo_q;
        wb_data = prod_lo_q;
`ifdef MUL_WB_HI_EN
        if (mul_gnt) state_d = WB_HI;
`else
        if (mul_gnt) state_d = IDLE;
        take = mul_req & mul_gnt;
`endif
      end
`ifdef MUL_WB_HI_EN
      WB_HI: begin
        wb_req  = 1'b1;
        wb_addr = rd_hi_q;
        wb_data = prod_hi_q;
        if (mul_gnt) state_d = IDLE;
        take = mul_req & mul_gnt;
      end
`endif
      default: state_d = IDLE;
    endcase
    // Final writeback edge doubles as the IDLE entry edge for back-to-back issue
    if (take) begin
      state_d = EXEC;
      cnt_d   = '0;
      rd_lo_d = mul_rd_lo;
`ifdef MUL_WB_HI_EN
      rd_hi_d = mul_rd_hi;
`endif
      ack_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_lo_q   <= '0;
      prod_lo_q <= '0;
`ifdef MUL_WB_HI_EN
      rd_hi_q   <= '0;
      prod_hi_q <= '0;
`endif
      ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_lo_q   <= rd_lo_d;
      prod_lo_q <= prod_lo_d;
`ifdef MUL_WB_HI_EN
      rd_hi_q   <= rd_hi_d;
      prod_hi_q <= prod_hi_d;
`endif
      ack_q <= ack_d;
    end
  end

  assign mul_ack = ack_q;
  assign mul_en  = (state_q == EXEC);
  assign busy    = (state_q != IDLE);
  assign stall   = busy;

endmodule

// File: tb/tb_mul_wb_scheduler.sv
// Scoreboard bench for mul_wb_scheduler: expected writes and acks are
// queued at issue time and popped by a negedge monitor.
module tb_mul_wb_scheduler;

  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int LAT = 4;
`ifdef MUL_WB_HI_EN
  localparam int HI = 1;
`else
  localparam int HI = 0;
`endif
  localparam int SEQ = LAT + 1 + HI;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mul_req = 1'b0;
  logic [AW-1:0] mul_rd_lo = '0;
  logic [AW-1:0] mul_rd_hi = '0;
  logic [DW-1:0] mul_lo = '0;
  logic [DW-1:0] mul_hi = '0;
  logic          alu_wr_req = 1'b0;
  logic [AW-1:0] alu_wr_reg = '0;
  logic [DW-1:0] alu_wr_data = '0;
  logic          mul_ack, mul_en, rf_we, stall, busy;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  mul_wb_scheduler #(
    .DATA_W(DW),
    .REG_AW(AW),
    .MUL_LAT(LAT)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (rst_n),
    .mul_req    (mul_req),
    .mul_rd_lo  (mul_rd_lo),
    .mul_rd_hi  (mul_rd_hi),
    .mul_ack    (mul_ack),
    .mul_en     (mul_en),
    .mul_lo     (mul_lo),
    .mul_hi     (mul_hi),
    .alu_wr_req (alu_wr_req),
    .alu_wr_reg (alu_wr_reg),
    .alu_wr_data(alu_wr_data),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .stall      (stall),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  wr_t         wq[$];
  int          aq[$];
  int          errors = 0;
  int          checks = 0;
  int          en_cnt = 0;
  logic [DW-1:0] regs[16];
  wr_t         w;
  int          e;
  int          b;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", n, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (mul_en) en_cnt++;
    if (mul_ack) begin
      if (aq.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = aq.pop_front();
        chk("ack_cyc", cyc, e);
      end
    end
    if (rf_we) begin
      regs[rf_waddr] = rf_wdata;
      if (wq.size() == 0) begin
        chk("unexpected_wr", {rf_waddr, rf_wdata}, 32'd0);
      end else begin
        w = wq.pop_front();
        chk("wr_cyc", cyc, w.cyc);
        chk("wr_addr", rf_waddr, w.addr);
        chk("wr_data", rf_wdata, w.data);
      end
    end
  end

  task automatic wait_to(input int c);
    int n = 0;
    while (cyc < c && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (cyc != c) chk("wait_to", cyc, c);
  endtask

  task automatic issue(input int la, input int ha, input int ld,
                       input int hd, output int base);
    base      = cyc + 1;
    mul_rd_lo = AW'(la);
    mul_rd_hi = AW'(ha);
    mul_lo    = DW'(ld);
    mul_hi    = DW'(hd);
    mul_req   = 1'b1;
    aq.push_back(base);
    wait_to(base);
    mul_req = 1'b0;
  endtask

  task automatic push_seq(input int base, input int la, input int ha,
                          input int ld, input int hd, input int dly);
    wq.push_back('{base + LAT + dly, la, ld});
    if (HI == 1) wq.push_back('{base + LAT + 1 + dly, ha, hd});
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_ack"}, mul_ack, 0);
    chk({n, "_en"}, mul_en, 0);
    chk({n, "_stall"}, stall, 0);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_we"}, rf_we, 0);
    chk({n, "_waddr"}, rf_waddr, 0);
    chk({n, "_wdata"}, rf_wdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("in_reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("post_reset");

    en_cnt = 0;
    issue(3, 4, 16'h00F0, 16'h0001, b);
    push_seq(b, 3, 4, 16'h00F0, 16'h0001, 0);
    wait_to(b + SEQ - 1);
    chk("t1_stall_busy", stall, 1);
    wait_to(b + SEQ);
    chk("t1_stall_done", stall, 0);
    chk("t1_en_cycles", en_cnt, LAT);

    wait_to(cyc + 2);
    issue(3, 4, 16'hBEEF, 16'hCAFE, b);
    wq.push_back('{b + LAT, 7, 16'h1234});
    wq.push_back('{b + LAT + 1, 7, 16'h1234});
    push_seq(b, 3, 4, 16'hBEEF, 16'hCAFE, 2);
    alu_wr_reg  = 4'd7;
    alu_wr_data = 16'h1234;
    wait_to(b + LAT);
    alu_wr_req = 1'b1;
    wait_to(b + LAT + 2);
    alu_wr_req = 1'b0;
    wait_to(b + SEQ + 1);
    chk("t2_stall_busy", stall, 1);
    wait_to(b + SEQ + 2);
    chk("t2_stall_done", stall, 0);

    wait_to(cyc + 2);
    b         = cyc + 1;
    mul_rd_lo = 4'd1;
    mul_rd_hi = 4'd2;
    mul_lo    = 16'h1111;
    mul_hi    = 16'h2222;
    mul_req   = 1'b1;
    for (int i = 0; i * SEQ <= 19; i++) begin
      aq.push_back(b + i * SEQ);
      push_seq(b + i * SEQ, 1, 2, 16'h1111, 16'h2222, 0);
    end
    wait_to(b + 19);
    mul_req = 1'b0;
    wait_to(b + (19 / SEQ) * SEQ + SEQ);
    chk("t3_stall_done", stall, 0);
    chk("t3_acks_left", aq.size(), 0);

    wait_to(cyc + 2);
    issue(6, 8, 16'h0BAD, 16'hF00D, b);
    wait_to(b + 2);
    chk("t4_en_before", mul_en, 1);
    rst_n      = 1'b0;
    alu_wr_req = 1'b1;
    #1;
    chk_zero("t4_async");
    @(posedge clk);
    #1;
    chk("t4_we_forced", rf_we, 0);
    alu_wr_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_to(cyc + 10);
    chk("t4_idle", busy, 0);

    issue(5, 5, 16'h0055, 16'hA5A5, b);
    push_seq(b, 5, 5, 16'h0055, 16'hA5A5, 0);
    wait_to(b + SEQ);
    chk("t5_stall_done", stall, 0);
    chk("t5_reg5", regs[5], (HI == 1) ? 16'hA5A5 : 16'h0055);

    wait_to(cyc + 3);
    chk("wq_empty", wq.size(), 0);
    chk("aq_empty", aq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_wb_scheduler.md
# mul_wb_scheduler

Multi-cycle sequencer and write-port arbiter for the 16-bit datapath multiplier. It accepts a multiply issue from the control unit and drives the multiplier enable for a fixed latency. It captures the 32-bit product and writes the low and high halves into the register bank over its single write port. ALU writeback always takes priority on that port. While a multiply is in flight, the block stalls PC/instruction advance.

## Interface
Parameters:
- DATA_W, 16, datapath and register width
- REG_AW, 4, register-bank address width
- MUL_LAT, 4, multiplier latency in cycles, legal range 1..15

Ports:
- CLOCK_50  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- mul_req  in  1  multiply issue request, level, held until acked
- mul_rd_lo  in  REG_AW  destination register for low product half
- mul_rd_hi  in  REG_AW  destination register for high product half
- mul_ack  out  1  one-cycle pulse: request accepted, destinations latched
- mul_en  out  1  multiplier enable
- mul_lo  in  DATA_W  multiplier low result
- mul_hi  in  DATA_W  multiplier high result
- alu_wr_req  in  1  ALU writeback request this cycle
- alu_wr_reg  in  REG_AW  ALU destination register
- alu_wr_data  in  DATA_W  ALU result
- rf_we  out  1  register-bank write enable
- rf_waddr  out  REG_AW  register-bank write address
- rf_wdata  out  DATA_W  register-bank write data
- stall  out  1  freeze PC and control advance
- busy  out  1  multiply sequence in progress (state != IDLE)

## Operation
- States: IDLE, EXEC, WB_LO, WB_HI.
- IDLE:
  - mul_req sampled high → latch mul_rd_lo/hi, pulse mul_ack, clear cycle counter, go to EXEC.
  - Requests are accepted only in IDLE.
- EXEC:
  - mul_en=1 and counter increments.
  - On the edge where counter==MUL_LAT-1: capture mul_lo/mul_hi into internal product registers, go to WB_LO.
- WB_LO:
  - If alu_wr_req=0: write the captured lo value to rd_lo, go to WB_HI.
  - Else: the ALU write takes the port and the state holds.
- WB_HI: same rule with the hi value and rd_hi; next state is IDLE.
- Arbitration:
  - Fixed priority, ALU first. rf_* are combinational from state and alu_* inputs.
  - The ALU is never refused, so no ALU ack exists.
- stall=1 and busy=1 in every non-IDLE state.
- rd_lo==rd_hi is legal: both writes occur and the hi value persists.
- Reset values: state IDLE, counter 0, product registers 0. Outputs mul_ack, mul_en, stall, busy, rf_we, rf_waddr and rf_wdata are all 0, and rf_we is forced to 0 while reset is low.
- Reset mid-sequence aborts immediately and discards captured data. No partial write is issued after release.

## Timing
- mul_req high at edge k (IDLE): mul_ack=1 during cycle k→k+1; mul_en=1 for cycles k..k+MUL_LAT-1.
- No ALU contention: lo written in cycle k+MUL_LAT, hi written in cycle k+MUL_LAT+1, IDLE from edge k+MUL_LAT+2.
- Each ALU write in WB_LO/WB_HI delays the remaining sequence by exactly one cycle.
- Earliest next acceptance is the first edge after IDLE is entered, so a back-to-back mul_req is acked at edge k+MUL_LAT+2.
- mul_req held continuously produces exactly one ack per sequence.

## Configuration
- MUL_WB_HI_EN defined: full sequence, both halves written (WB_HI present).
- Undefined: WB_HI omitted; WB_LO returns to IDLE. mul_rd_hi is ignored and the high product register is not built. Latency drops by one cycle.

## Structure
- Package mul_sched_pkg: state enum (IDLE, EXEC, WB_LO, WB_HI), DATA_W/REG_AW defaults, counter width constant (4 bits).
- One sub-module, wb_arbiter: 2-way fixed-priority write-port mux. It outputs a grant to the FSM so the FSM knows when to hold.

## Test plan
- Reset, then mul_req=1 with rd_lo=3, rd_hi=4, mul_lo=0x00F0, mul_hi=0x0001, MUL_LAT=4, no ALU traffic.
  - Required: ack at edge 0, mul_en for 4 cycles.
  - Required: reg 3←0x00F0 in cycle 4, reg 4←0x0001 in cycle 5, stall low from cycle 6.
- alu_wr_req=1 (reg 7, 0x1234) during WB_LO for 2 cycles.
  - Required: rf port shows ALU writes first, lo write slips 2 cycles, total sequence length 8.
- mul_req held high continuously for 20 cycles (MUL_LAT=4).
  - Required: acks at edges 0, 6, 12, 18; never 2 acks within one sequence.
- reset driven low in EXEC cycle 2.
  - Required: all outputs 0 asynchronously, no rf_we after release, next mul_req acked normally.
- rd_lo=rd_hi=5.
  - Required: two consecutive writes to reg 5, final value equals the mul_hi capture.
- Build without MUL_WB_HI_EN.
  - Required: only the lo write occurs, IDLE at edge MUL_LAT+1.
